fb_sram_arbiter: RTL and testbench

- Shares the single-port external framebuffer SRAM between two requesters: video scan-out reads (addressed from the sync generator's sram_addr) and drawing-engine pixel writes.
- Video reads have priority, with a bounded-starvation guard for writes.
- Sole driver of the SRAM control pins: sits between the sync generator/pixel pipeline and the SRAM pads.

---
 rtl/fb_sram_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_fb_sram_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_sram_arbiter.sv
// fb_sram_arbiter
// ---------------
// Shares one single-port asynchronous framebuffer SRAM between the video
// scan-out read path and the drawing-engine write path. This block is the
// only driver of the SRAM control pins. Video reads normally win. A write
// that has been waiting is forced through once MAX_VID_BURST video grants
// have been given while it waited (MAX_VID_BURST = 0 gives strict video
// priority).
//
// Handshake (both requesters): the requester raises *_req together with its
// address (and data, for writes) and holds them steady until it sees the
// one-cycle *_ack pulse. Requests are level sampled at arbitration points,
// and a request withdrawn before its ack is simply never serviced. Read data
// comes back later as a one-cycle vid_valid pulse with vid_data. There is no
// back-pressure on vid_valid.
//
// Ports:
//   clk, reset             system clock, asynchronous active-high reset
//   vid_req/vid_addr       video read request and word address
//   vid_ack                one-cycle pulse: read accepted
//   vid_data/vid_valid     read data and its one-cycle qualifier
//   wr_req/wr_addr/wr_data drawing-engine write request, address and data
//   wr_ack                 one-cycle pulse: write accepted
//   sram_addr              SRAM address pins
//   sram_dq_o/sram_dq_oe   SRAM write data and data-bus output enable
//   sram_dq_i              SRAM read data
//   sram_ce_n/oe_n/we_n    SRAM strobes, active low
//   dbg_state              current FSM state: 0 IDLE, 1 RD, 2 WS, 3 WP, 4 WH
//
// All outputs are registers.

module fb_sram_arbiter #(
  parameter int ADDR_W        = 19,
  parameter int DATA_W        = 16,
  parameter int READ_CYCLES   = 2,
  parameter int WR_PULSE      = 1,
  parameter int MAX_VID_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WS   = 3'd2,
    WP   = 3'd3,
    WH   = 3'd4
  } state_t;

  // One shared cycle counter serves both the read window and the write pulse.
  localparam int CNT_MAX = (READ_CYCLES > WR_PULSE) ? READ_CYCLES : WR_PULSE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_CYCLES - 1);
  localparam logic [CNT_W-1:0] WP_LAST = CNT_W'(WR_PULSE - 1);

  // The burst counter must hold 0..MAX_VID_BURST. The +2 keeps the width at
  // least 1 bit even for MAX_VID_BURST = 0.
  localparam int BURST_W = $clog2(MAX_VID_BURST + 2);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_VID_BURST);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BURST_W-1:0] burst_cnt;

  logic rd_last;
  logic arb_point;
  logic write_forced;
  logic grant_vid;
  logic grant_wr;

  always_comb begin
    rd_last      = (state == RD) && (cnt == RD_LAST);
    // Decisions are only taken when the bus is free next cycle. A write in
    // flight is never interrupted.
    arb_point    = (state == IDLE) || rd_last || (state == WH);
    write_forced = wr_req && (MAX_VID_BURST != 0) && (burst_cnt == BURST_MAX);
    grant_vid    = arb_point && vid_req && !write_forced;
    grant_wr     = arb_point && wr_req && (write_forced || !vid_req);
  end

  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      burst_cnt  <= '0;
      vid_ack    <= 1'b0;
      vid_valid  <= 1'b0;
      vid_data   <= '0;
      wr_ack     <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      vid_ack   <= 1'b0;
      wr_ack    <= 1'b0;
      vid_valid <= 1'b0;

      // Count video grants handed out while a write is waiting. Any cycle
      // without a pending write, and any write grant, starts the count over.
      if (!wr_req || grant_wr) begin
        burst_cnt <= '0;
      end else if (grant_vid && (burst_cnt != BURST_MAX)) begin
        burst_cnt <= burst_cnt + 1'b1;
      end

      // Read data is taken at the end of the last cycle of the OE window.
      if (rd_last) begin
        vid_data  <= sram_dq_i;
        vid_valid <= 1'b1;
      end

      if (arb_point) begin
        if (grant_vid) begin
          state      <= RD;
          cnt        <= '0;
          vid_ack    <= 1'b1;
          sram_addr  <= vid_addr;
          sram_dq_oe <= 1'b0;
          sram_ce_n  <= 1'b0;
          sram_oe_n  <= 1'b0;
          sram_we_n  <= 1'b1;
        end else if (grant_wr) begin
          // OE_n rises on the same edge that enables the data drivers. The
          // SRAM and this block therefore never drive the bus together.
          state      <= WS;
          cnt        <= '0;
          wr_ack     <= 1'b1;
          sram_addr  <= wr_addr;
          sram_dq_o  <= wr_data;
          sram_dq_oe <= 1'b1;
          sram_ce_n  <= 1'b0;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
        end else begin
          state      <= IDLE;
          sram_dq_oe <= 1'b0;
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
        end
      end else begin
        case (state)
          RD: begin
            cnt <= cnt + 1'b1;
          end
          WS: begin
            state     <= WP;
            cnt       <= '0;
            sram_we_n <= 1'b0;
          end
          WP: begin
            if (cnt == WP_LAST) begin
              // Address, data and dq_oe stay put through WH.
              state     <= WH;
              sram_we_n <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            // Unused encodings fall back to a quiet idle bus.
            state      <= IDLE;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Bench for fb_sram_arbiter. Two configurations run side by side:
//   h[0]: READ_CYCLES=2, WR_PULSE=1, MAX_VID_BURST=8 (defaults)
//   h[1]: READ_CYCLES=3, WR_PULSE=2, MAX_VID_BURST=0 (strict video priority)
// In each configuration, the driver tasks push the expected read data and
// write records when they issue a request. A negedge monitor pops those
// records and checks them against what the DUT and the SRAM pins present.
// The SRAM read model returns a fixed function of the address.

`timescale 1ns/1ps

module tb_fb_sram_arbiter;

  localparam int AW = 19;
  localparam int DW = 16;

  // Clock/reset block (resets live per configuration below).
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  bit done [2];

  task automatic chk(input int hx, input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL c%0d %s: got %0h expected %0h (cycle %0d)", hx, name, got, exp, cyc);
    end
  endtask

  // Behavioural SRAM contents: a fixed word per address.
  function automatic logic [DW-1:0] sram_func(input logic [AW-1:0] a);
    if (a == 19'h00123) return 16'hBEEF;
    return a[15:0] ^ {a[18:16], a[12:0]} ^ 16'h5A3C;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : h
    localparam int RC      = (g == 0) ? 2 : 3;
    localparam int WPL     = (g == 0) ? 1 : 2;
    localparam int MAXB    = (g == 0) ? 8 : 0;
    localparam int NSTREAM = 20;

    logic          rst;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq_o;
    logic          sram_dq_oe;
    logic [DW-1:0] sram_dq_i;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [2:0]    dbg_state;

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_func(sram_addr) : 16'hDEAD;

    fb_sram_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .READ_CYCLES(RC), .WR_PULSE(WPL), .MAX_VID_BURST(MAXB)
    ) dut (
      .clk(clk), .reset(rst),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
      .vid_data(vid_data), .vid_valid(vid_valid),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
      .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .dbg_state(dbg_state)
    );

    // Scoreboard queues
    logic [DW-1:0]    rd_exp_q[$];
    logic [AW+DW-1:0] wr_exp_q[$];
    int               valid_t_q[$];
    int               fall_t_q[$];

    int vid_ack_cnt  = 0;
    int wr_ack_cnt   = 0;
    int vid_ack_at_wr = 0;
    int max_lat      = 0;

    // Monitor state
    logic          p_vid_req  = 1'b0;
    logic          p_wr_req   = 1'b0;
    logic          p_we_n     = 1'b1;
    logic [AW-1:0] p_vid_addr = '0;
    logic [AW-1:0] p_wr_addr  = '0;
    logic [DW-1:0] p_wr_data  = '0;
    logic [7:0]    oe_hist    = '0;
    int            low_cnt    = 0;
    logic [AW-1:0] w_addr     = '0;
    logic [DW-1:0] w_data     = '0;

    always @(negedge clk) begin
      if (rst) begin
        p_vid_req = 1'b0;
        p_wr_req  = 1'b0;
        p_we_n    = 1'b1;
        oe_hist   = '0;
        low_cnt   = 0;
      end else begin
        chk(g, "bus_oe_and_dq_oe", 64'(!sram_oe_n && sram_dq_oe), 64'(0));
        if (!sram_we_n)
          chk(g, "we_low_outside_write", 64'({sram_ce_n, sram_dq_oe, sram_oe_n}), 64'(3'b011));

        if (vid_valid) begin
          chk(g, "vid_valid_expected", 64'(valid_t_q.size() != 0 && rd_exp_q.size() != 0), 64'(1));
          if (valid_t_q.size() != 0 && rd_exp_q.size() != 0) begin
            chk(g, "vid_valid_cycle", 64'(cyc), 64'(valid_t_q.pop_front()));
            chk(g, "vid_data", 64'(vid_data), 64'(rd_exp_q.pop_front()));
            chk(g, "rd_oe_window", 64'(oe_hist & ((8'd1 << RC) - 8'd1)), 64'((8'd1 << RC) - 8'd1));
          end
        end

        if (vid_ack) begin
          chk(g, "vid_ack_without_req", 64'(p_vid_req), 64'(1));
          chk(g, "rd_addr", 64'(sram_addr), 64'(p_vid_addr));
          vid_ack_cnt++;
          valid_t_q.push_back(cyc + RC);
        end

        if (wr_ack) begin
          chk(g, "wr_ack_without_req", 64'(p_wr_req), 64'(1));
          chk(g, "ws_pins", 64'({sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n}),
              64'({p_wr_addr, p_wr_data, 4'b1011}));
          wr_ack_cnt++;
          vid_ack_at_wr = vid_ack_cnt;
          fall_t_q.push_back(cyc + 1);
        end

        if (p_we_n && !sram_we_n) begin
          chk(g, "we_fall_expected", 64'(fall_t_q.size() != 0), 64'(1));
          if (fall_t_q.size() != 0) chk(g, "we_fall_cycle", 64'(cyc), 64'(fall_t_q.pop_front()));
          w_addr  = sram_addr;
          w_data  = sram_dq_o;
          low_cnt = 1;
        end else if (!p_we_n && !sram_we_n) begin
          low_cnt++;
          chk(g, "wp_stable", 64'({sram_addr, sram_dq_o}), 64'({w_addr, w_data}));
        end else if (!p_we_n && sram_we_n) begin
          chk(g, "we_pulse_len", 64'(low_cnt), 64'(WPL));
          chk(g, "wh_pins", 64'({sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n}),
              64'({w_addr, w_data, 3'b101}));
          chk(g, "write_expected", 64'(wr_exp_q.size() != 0), 64'(1));
          if (wr_exp_q.size() != 0)
            chk(g, "write_commit", 64'({sram_addr, sram_dq_o}), 64'(wr_exp_q.pop_front()));
        end

        p_vid_req  = vid_req;
        p_vid_addr = vid_addr;
        p_wr_req   = wr_req;
        p_wr_addr  = wr_addr;
        p_wr_data  = wr_data;
        p_we_n     = sram_we_n;
        oe_hist    = {oe_hist[6:0], !sram_oe_n};
      end
    end

    // Driver tasks: called #1 after a rising edge.
    task automatic idle(input int n);
      if (n > 0) begin
        repeat (n) @(posedge clk);
        #1;
      end
    endtask

    task automatic vid_read(input logic [AW-1:0] a, output int lat);
      int t0;
      int n;
      vid_addr = a;
      vid_req  = 1'b1;
      t0       = cyc;
      rd_exp_q.push_back(sram_func(a));
      n = 0;
      do begin @(negedge clk); n++; end while (!vid_ack && n < 64);
      chk(g, "vid_ack_timeout", 64'(vid_ack), 64'(1));
      lat = cyc - t0;
      if (lat > max_lat) max_lat = lat;
      @(posedge clk); #1;
      vid_req = 1'b0;
    endtask

    task automatic wr_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
      int t0;
      int n;
      wr_addr = a;
      wr_data = d;
      wr_req  = 1'b1;
      t0      = cyc;
      wr_exp_q.push_back({a, d});
      n = 0;
      do begin @(negedge clk); n++; end while (!wr_ack && n < 300);
      chk(g, "wr_ack_timeout", 64'(wr_ack), 64'(1));
      lat = cyc - t0;
      @(posedge clk); #1;
      wr_req = 1'b0;
    endtask

    initial begin
      int lat;
      int lat2;
      int base;
      int n;
      rst = 1'b1;
      vid_req = 1'b0; vid_addr = '0;
      wr_req  = 1'b0; wr_addr  = '0; wr_data = '0;
      repeat (2) @(posedge clk);
      #2;
      chk(g, "rst_ctrl", 64'({vid_ack, vid_valid, wr_ack, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n}),
          64'(7'b0000111));
      chk(g, "rst_addr", 64'(sram_addr), 64'(0));
      chk(g, "rst_data", 64'({vid_data, sram_dq_o}), 64'(0));
      chk(g, "rst_state", 64'(dbg_state), 64'(0));
      @(negedge clk); #2;
      rst = 1'b0;

      // Single read
      @(posedge clk); #1;
      vid_read(19'h00123, lat);
      chk(g, "single_read_ack_lat", 64'(lat), 64'(1));
      idle(5);

      // Single write
      wr_write(19'h4B000, 16'h1234, lat);
      chk(g, "single_write_ack_lat", 64'(lat), 64'(1));
      idle(5);

      // Simultaneous first requests: video first, write right behind it
      fork
        vid_read(19'h00456, lat);
        wr_write(19'h4C010, 16'hCAFE, lat2);
      join
      chk(g, "simul_vid_lat", 64'(lat), 64'(1));
      chk(g, "simul_wr_lat", 64'(lat2), 64'(RC + 1));
      idle(6);

      // Video request raised during a write and withdrawn before WH
      base = vid_ack_cnt;
      fork
        wr_write(19'h4D000, 16'h0F0F, lat2);
        begin
          n = 0;
          do begin @(negedge clk); n++; end while (!wr_ack && n < 64);
          @(posedge clk); #1;
          vid_addr = 19'h00777;
          vid_req  = 1'b1;
          @(posedge clk); #1;
          vid_req  = 1'b0;
        end
      join
      idle(8);
      chk(g, "dropped_req_no_ack", 64'(vid_ack_cnt - base), 64'(0));

      // Starvation guard: continuous video against one pending write
      base    = vid_ack_cnt;
      max_lat = 0;
      fork
        for (int i = 0; i < NSTREAM; i++) vid_read(19'h01000 + 19'(i), lat);
        wr_write(19'h4E000, 16'hA5A5, lat2);
      join
      idle(8);
      chk(g, "reads_before_write", 64'(vid_ack_at_wr - base), 64'((MAXB == 0) ? NSTREAM : MAXB));
      chk(g, "max_vid_wait", 64'(max_lat), 64'((MAXB == 0) ? (RC - 1) : (RC + WPL + 1)));

      // Random traffic
      max_lat = 0;
      fork
        for (int i = 0; i < 30; i++) begin
          idle($urandom_range(0, 3));
          vid_read({1'b0, 18'($urandom)}, lat);
        end
        for (int i = 0; i < 12; i++) begin
          idle($urandom_range(0, 6));
          wr_write({1'b1, 18'($urandom)}, 16'($urandom), lat2);
        end
      join
      idle(10);
      chk(g, "rand_max_wait_bound", 64'(max_lat <= RC + WPL + 1), 64'(1));
      chk(g, "rand_rd_drained", 64'(rd_exp_q.size() + valid_t_q.size()), 64'(0));
      chk(g, "rand_wr_drained", 64'(wr_exp_q.size() + fall_t_q.size()), 64'(0));

      // Asynchronous reset in the middle of the write pulse
      wr_addr = 19'h4F00F;
      wr_data = 16'h7777;
      wr_req  = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (sram_we_n && n < 64);
      chk(g, "wp_reached", 64'(sram_we_n), 64'(0));
      #2;
      rst = 1'b1;
      #1;
      chk(g, "rst_async_pins", 64'({sram_we_n, sram_ce_n, sram_oe_n, sram_dq_oe}), 64'(4'b1110));
      chk(g, "rst_async_state", 64'(dbg_state), 64'(0));
      wr_req = 1'b0;
      rd_exp_q.delete();
      valid_t_q.delete();
      wr_exp_q.delete();
      fall_t_q.delete();
      @(negedge clk); #2;
      rst = 1'b0;
      base = wr_ack_cnt;
      n    = vid_ack_cnt;
      idle(6);
      chk(g, "no_wr_ack_after_reset", 64'(wr_ack_cnt - base), 64'(0));
      chk(g, "no_vid_ack_after_reset", 64'(vid_ack_cnt - n), 64'(0));
      vid_read(19'h00321, lat);
      chk(g, "read_after_reset_lat", 64'(lat), 64'(1));
      idle(6);
      chk(g, "final_drained", 64'(rd_exp_q.size() + valid_t_q.size() + wr_exp_q.size() + fall_t_q.size()),
          64'(0));
      done[g] = 1'b1;
    end
  end

  // Final report
  initial begin
    fork
      wait (done[0] && done[1]);
      begin
        repeat (30000) @(posedge clk);
        vectors++;
        miscompares++;
        $display("FAIL watchdog: got no completion, expected both configurations done");
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
